// File: rtl/l2_bank_array_pkg.sv
// Shared types and constants for the interleaved L2 bank array.
package l2_bank_array_pkg;

  typedef enum logic {INIT, READY} init_state_e;

  localparam logic [31:0] ERR_RDATA   = 32'hBADA_CCE5;
  localparam int unsigned MIN_LATENCY = 1;
  localparam int unsigned MAX_LATENCY = 3;

  // Bytes covered by the whole interleaved region.
  function automatic logic [63:0] region_bytes(input int unsigned nb_banks,
                                               input int unsigned bank_words);
    return 64'(nb_banks) * 64'(bank_words) * 64'd4;
  endfunction

endpackage

// File: rtl/l2_bank_array_port.sv
// One bank slave port: range check, sweep/port write mux, SRAM and response pipe.
module l2_bank_port
  import l2_bank_array_pkg::*;
#(
  parameter int unsigned NB_BANKS   = 4,
  parameter int unsigned BANK_WORDS = 32768,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h1C00_0000,
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned AW         = (BANK_WORDS > 1) ? $clog2(BANK_WORDS) : 1,
  parameter int unsigned BE_W       = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  gnt_en_i,
  input  logic                  init_we_i,
  input  logic [AW-1:0]         init_addr_i,
  input  logic                  req_i,
  input  logic [31:0]           add_i,
  input  logic                  wen_i,
  input  logic [BE_W-1:0]       be_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  gnt_o,
  output logic                  r_valid_o,
  output logic [DATA_WIDTH-1:0] r_rdata_o,
  output logic                  r_opc_o
);

  localparam int unsigned BSEL_W = (NB_BANKS > 1) ? $clog2(NB_BANKS) : 0;
  localparam logic [63:0] REGION = region_bytes(NB_BANKS, BANK_WORDS);
  localparam logic [DATA_WIDTH-1:0] ERR_W = DATA_WIDTH'(ERR_RDATA);

  typedef struct packed {
    logic                  valid;
    logic                  opc;
    logic [DATA_WIDTH-1:0] rdata;
  } resp_t;

  logic [31:0]           off;
  logic                  in_range, gnt;
  logic                  sram_req, sram_we;
  logic [AW-1:0]         sram_addr;
  logic [DATA_WIDTH-1:0] sram_wdata, sram_rdata;
  logic [BE_W-1:0]       sram_be;
  logic                  valid_q, opc_q, rd_q;
  resp_t                 resp_s1, resp_out;

  // Wrapping subtraction folds addresses below the base into the error range.
  assign off      = add_i - BASE_ADDR;
  assign in_range = {32'd0, off} < REGION;
  assign gnt      = req_i & gnt_en_i;
  assign gnt_o    = gnt;

  assign sram_req   = init_we_i | (gnt & in_range);
  assign sram_we    = init_we_i | ~wen_i;
  assign sram_addr  = init_we_i ? init_addr_i : off[2+BSEL_W +: AW];
  assign sram_wdata = init_we_i ? '0 : wdata_i;
  assign sram_be    = init_we_i ? {BE_W{1'b1}} : be_i;

  tc_sram #(
    .NumWords (BANK_WORDS),
    .DataWidth(DATA_WIDTH),
    .AddrWidth(AW),
    .BeWidth  (BE_W)
  ) i_sram (
    .clk_i  (clk_i),
    .req_i  (sram_req),
    .we_i   (sram_we),
    .addr_i (sram_addr),
    .wdata_i(sram_wdata),
    .be_i   (sram_be),
    .rdata_o(sram_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the clock edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      opc_q   <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      valid_q <= gnt;
      opc_q   <= gnt & ~in_range;
      rd_q    <= gnt & wen_i;
    end
  end

  always_comb begin
    resp_s1       = '0;
    resp_s1.valid = valid_q;
    resp_s1.opc   = opc_q;
    if (rd_q) resp_s1.rdata = opc_q ? ERR_W : sram_rdata;
  end

  if (LATENCY <= 1) begin : g_lat1
    assign resp_out = resp_s1;
  end else begin : g_pipe
    resp_t pipe_q [LATENCY-1];
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int i = 0; i < LATENCY - 1; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= resp_s1;
        for (int i = 1; i < LATENCY - 1; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end
    assign resp_out = pipe_q[LATENCY-2];
  end

  assign r_valid_o = resp_out.valid;
  assign r_opc_o   = resp_out.opc;
  assign r_rdata_o = resp_out.rdata;

endmodule

// File: rtl/tc_sram.sv
// Single-port SRAM macro model with byte enables and a registered read port.
module tc_sram #(
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
  parameter int unsigned BeWidth   = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [BeWidth-1:0]   be_i,
  output logic [DataWidth-1:0] rdata_o
);

  logic [DataWidth-1:0] mem_q [NumWords];
  logic [DataWidth-1:0] rdata_q;

  // NOTE: the storage array and its read register carry no reset; the
  // zero-init sweep and the response valid gating make that safe.
  always_ff @(posedge clk_i) begin
    if (req_i) begin
      if (we_i) begin
        for (int i = 0; i < BeWidth; i++) begin
          if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/l2_bank_array.sv
// Multi-bank L2 SRAM array: init-sweep FSM, sweep counter and per-bank ports.
module l2_bank_array
  import l2_bank_array_pkg::*;
#(
  parameter int unsigned NB_BANKS      = 4,
  parameter int unsigned BANK_WORDS    = 32768,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter logic [31:0] BASE_ADDR     = 32'h1C00_0000,
  parameter int unsigned LATENCY       = 1,
  parameter bit          INIT_ON_RESET = 1'b1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 init_req_i,
  output logic                                 init_busy_o,
  input  logic [NB_BANKS-1:0]                  req_i,
  input  logic [NB_BANKS-1:0][31:0]            add_i,
  input  logic [NB_BANKS-1:0]                  wen_i,
  input  logic [NB_BANKS-1:0][DATA_WIDTH/8-1:0] be_i,
  input  logic [NB_BANKS-1:0][DATA_WIDTH-1:0]  wdata_i,
  output logic [NB_BANKS-1:0]                  gnt_o,
  output logic [NB_BANKS-1:0]                  r_valid_o,
  output logic [NB_BANKS-1:0][DATA_WIDTH-1:0]  r_rdata_o,
  output logic [NB_BANKS-1:0]                  r_opc_o
);

  localparam int unsigned AW = (BANK_WORDS > 1) ? $clog2(BANK_WORDS) : 1;

  if (LATENCY < MIN_LATENCY || LATENCY > MAX_LATENCY) begin : g_bad_latency
    $error("l2_bank_array: LATENCY must be in 1..3");
  end

  init_state_e   state_q;
  logic [AW-1:0] cnt_q;
  logic          grant_en, sweep_we;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= INIT_ON_RESET ? INIT : READY;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        INIT: begin
          if (cnt_q == AW'(BANK_WORDS - 1)) begin
            state_q <= READY;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        READY: if (init_req_i) state_q <= INIT;
        default: state_q <= READY;
      endcase
    end
  end

  // Reset masks the state so all outputs read as idle while it is held.
  assign grant_en    = (state_q == READY) & ~rst_i;
  assign sweep_we    = (state_q == INIT) & ~rst_i;
  assign init_busy_o = sweep_we;

  for (genvar b = 0; b < NB_BANKS; b++) begin : g_bank
    l2_bank_port #(
      .NB_BANKS  (NB_BANKS),
      .BANK_WORDS(BANK_WORDS),
      .DATA_WIDTH(DATA_WIDTH),
      .BASE_ADDR (BASE_ADDR),
      .LATENCY   (LATENCY),
      .AW        (AW)
    ) i_port (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .gnt_en_i   (grant_en),
      .init_we_i  (sweep_we),
      .init_addr_i(cnt_q),
      .req_i      (req_i[b]),
      .add_i      (add_i[b]),
      .wen_i      (wen_i[b]),
      .be_i       (be_i[b]),
      .wdata_i    (wdata_i[b]),
      .gnt_o      (gnt_o[b]),
      .r_valid_o  (r_valid_o[b]),
      .r_rdata_o  (r_rdata_o[b]),
      .r_opc_o    (r_opc_o[b])
    );
  end

endmodule

// File: tb/tb_l2_bank_array.sv
// Directed bench for l2_bank_array: 4 banks x 16 words, 3-cycle read latency.
module tb_l2_bank_array;
  import l2_bank_array_pkg::*;

  localparam int          NB     = 4;
  localparam int          WORDS  = 16;
  localparam int          LAT    = 3;
  localparam logic [31:0] BASE   = 32'h1C00_0000;
  localparam logic [31:0] REGION = 32'd256;

  logic                 clk = 1'b0;
  logic                 rst, init_req, init_busy;
  logic [NB-1:0]        req, wen, gnt, r_valid, r_opc;
  logic [NB-1:0][31:0]  add, wdata, r_rdata;
  logic [NB-1:0][3:0]   be;

  always #5 clk = ~clk;

  l2_bank_array #(
    .NB_BANKS(NB), .BANK_WORDS(WORDS), .DATA_WIDTH(32), .BASE_ADDR(BASE),
    .LATENCY(LAT), .INIT_ON_RESET(1'b1)
  ) dut (
    .clk_i(clk), .rst_i(rst), .init_req_i(init_req), .init_busy_o(init_busy),
    .req_i(req), .add_i(add), .wen_i(wen), .be_i(be), .wdata_i(wdata),
    .gnt_o(gnt), .r_valid_o(r_valid), .r_rdata_o(r_rdata), .r_opc_o(r_opc)
  );

  typedef struct {
    int          due;
    logic        opc;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q [NB][$];
  exp_t        mon_e;
  logic [31:0] mem [NB][WORDS];
  logic [NB-1:0]       ov_en;
  logic [NB-1:0][31:0] ov_data;
  int n_push [NB];
  int n_valid [NB];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic set_req(input int b, input logic [31:0] a, input logic w,
                         input logic [3:0] bmask, input logic [31:0] d);
    req[b] = 1'b1; add[b] = a; wen[b] = w; be[b] = bmask; wdata[b] = d;
  endtask

  task automatic idle();
    req = '0; ov_en = '0;
  endtask

  task automatic zero_model();
    for (int b = 0; b < NB; b++)
      for (int w = 0; w < WORDS; w++) mem[b][w] = 32'h0;
  endtask

  // Expected response for a granted request, from the bench's own memory model.
  task automatic push(input int b);
    exp_t        e;
    logic [31:0] off;
    int          idx;
    off     = add[b] - BASE;
    e.due   = cyc + LAT;
    e.opc   = 1'b0;
    e.rdata = 32'h0;
    if (off >= REGION) begin
      e.opc = 1'b1;
      if (wen[b]) e.rdata = 32'hBADACCE5;
    end else begin
      idx = int'(off[7:4]);
      if (wen[b]) e.rdata = mem[b][idx];
      else
        for (int k = 0; k < 4; k++)
          if (be[b][k]) mem[b][idx][8*k +: 8] = wdata[b][8*k +: 8];
    end
    if (ov_en[b]) e.rdata = ov_data[b];
    exp_q[b].push_back(e);
    n_push[b]++;
  endtask

  // One cycle in normal operation: ready says whether grants are expected.
  task automatic tick(input logic ready);
    #1;
    check("init_busy", init_busy, !ready);
    for (int b = 0; b < NB; b++) begin
      logic g;
      g = req[b] & ready;
      check($sformatf("gnt%0d", b), gnt[b], g);
      if (g) push(b);
    end
    @(negedge clk);
  endtask

  task automatic reset_tick();
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_busy", init_busy, 0);
    check("rst_valid", r_valid, 0);
    check("rst_opc", r_opc, 0);
    check("rst_rdata_lo", r_rdata[1:0], 0);
    check("rst_rdata_hi", r_rdata[3:2], 0);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    #2;
    for (int b = 0; b < NB; b++) begin
      if (r_valid[b]) begin
        if (exp_q[b].size() == 0) begin
          check($sformatf("spurious_valid%0d", b), r_valid[b], 0);
        end else begin
          mon_e = exp_q[b].pop_front();
          n_valid[b]++;
          check($sformatf("resp_cycle%0d", b), cyc, mon_e.due);
          check($sformatf("resp_opc%0d", b), r_opc[b], mon_e.opc);
          check($sformatf("resp_rdata%0d", b), r_rdata[b], mon_e.rdata);
        end
      end else if (exp_q[b].size() != 0 && exp_q[b][0].due <= cyc) begin
        check($sformatf("missing_valid%0d", b), r_valid[b], 1);
        void'(exp_q[b].pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; init_req = 1'b0;
    req = '1; add = '0; wen = '1; be = '0; wdata = '0; ov_en = '0; ov_data = '0;
    for (int b = 0; b < NB; b++) begin n_push[b] = 0; n_valid[b] = 0; end
    zero_model();

    // Reset, then the power-on sweep with requests held high (none granted).
    @(negedge clk);
    repeat (3) reset_tick();
    rst = 1'b0;
    repeat (WORDS) tick(1'b0);

    // Every word of every bank reads back zero, all banks every cycle.
    for (int w = 0; w < WORDS; w++) begin
      for (int b = 0; b < NB; b++) set_req(b, BASE + 32'(w * 16 + b * 4), 1'b1, 4'hF, 32'h0);
      tick(1'b1);
    end
    idle();

    // Partial-byte write then immediate read of the same word.
    set_req(0, BASE + 32'h10, 1'b0, 4'b0101, 32'hDEADBEEF);
    tick(1'b1);
    set_req(0, BASE + 32'h10, 1'b1, 4'hF, 32'h0);
    ov_en[0] = 1'b1; ov_data[0] = 32'h00AD00EF;
    tick(1'b1);
    idle();

    // Out-of-range reads below and above the region, plus an out-of-range write.
    set_req(1, BASE - 32'd4, 1'b1, 4'hF, 32'h0);
    ov_en[1] = 1'b1; ov_data[1] = 32'hBADACCE5;
    set_req(2, BASE + REGION, 1'b1, 4'hF, 32'h0);
    ov_en[2] = 1'b1; ov_data[2] = 32'hBADACCE5;
    set_req(0, BASE + REGION + 32'h10, 1'b0, 4'hF, 32'h12345678);
    tick(1'b1);
    idle();
    set_req(0, BASE + 32'h10, 1'b1, 4'hF, 32'h0);
    ov_en[0] = 1'b1; ov_data[0] = 32'h00AD00EF;
    tick(1'b1);
    idle();

    // All banks request every cycle for 8 cycles: 4 writes then 4 reads.
    for (int c = 0; c < 8; c++) begin
      for (int b = 0; b < NB; b++)
        set_req(b, BASE + 32'(((c % 4) + 4) * 16 + b * 4), (c >= 4), 4'hF,
                32'hA000_0000 | 32'(b << 8) | 32'(c));
      tick(1'b1);
    end
    idle();

    // Sweep requested with a read in flight; a second pulse mid-sweep is ignored.
    set_req(0, BASE + 32'h10, 1'b1, 4'hF, 32'h0);
    ov_en[0] = 1'b1; ov_data[0] = 32'h00AD00EF;
    init_req = 1'b1;
    tick(1'b1);
    init_req = 1'b0; ov_en = '0;
    zero_model();
    repeat (5) tick(1'b0);
    init_req = 1'b1;
    tick(1'b0);
    init_req = 1'b0;
    repeat (WORDS - 6) tick(1'b0);
    idle();
    set_req(0, BASE + 32'h10, 1'b1, 4'hF, 32'h0);
    tick(1'b1);
    idle();
    repeat (LAT + 1) tick(1'b1);

    // Reset in cycle 5 of a sweep aborts it; a full sweep follows.
    init_req = 1'b1;
    tick(1'b1);
    init_req = 1'b0;
    repeat (5) tick(1'b0);
    rst = 1'b1; req = '1;
    repeat (2) reset_tick();
    rst = 1'b0;
    repeat (WORDS) tick(1'b0);
    idle();
    for (int b = 0; b < NB; b++) set_req(b, BASE + 32'(16 + b * 4), 1'b1, 4'hF, 32'h0);
    tick(1'b1);
    idle();

    repeat (LAT + 2) tick(1'b1);
    for (int b = 0; b < NB; b++) begin
      check($sformatf("valid_count%0d", b), n_valid[b], n_push[b]);
      check($sformatf("queue_empty%0d", b), exp_q[b].size(), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
